rv_fetch_pc: RTL and testbench

//  Program-counter and instruction-fetch stage of the single-cycle RV32I core.

---
 rtl/rv_fetch_pc_pkg.sv | 17 +
 rtl/rv_fetch_pc_next_pc.sv | 36 +++
 rtl/rv_fetch_pc.sv | 147 ++++++++++++++
 tb/tb_rv_fetch_pc.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pc_pkg.sv
// Shared definitions for the rv_fetch_pc slice.
//  - 2-bit fetch FSM state codes.
//  - Default reset vector.
//  - Helper that clears bit 0 of a jump target (jalr semantics).
package rv_fetch_pc_pkg;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] clear_lsb(input logic [31:0] a);
    return {a[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/rv_fetch_pc_next_pc.sv
// Next-PC selection for the fetch stage (purely combinational).
//  pc         in   32  address of the current instruction
//  br_en      in   1   current instruction is a conditional branch
//  br_inv     in   1   invert the branch condition
//  alu_zero   in   1   ALU zero flag
//  jump       in   1   unconditional jal/jalr
//  target     in   32  branch/jump target from the datapath
//  pc_plus4   out  32  sequential successor (wraps modulo 2^32)
//  taken      out  1   control transfer is taken
//  nxt        out  32  selected next PC, bit 0 cleared on taken paths
//  bad_target out  1   taken target is not 4-byte aligned
module rv_fetch_pc_next_pc
  import rv_fetch_pc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        br_en,
  input  logic        br_inv,
  input  logic        alu_zero,
  input  logic        jump,
  input  logic [31:0] target,
  output logic [31:0] pc_plus4,
  output logic        taken,
  output logic [31:0] nxt,
  output logic        bad_target
);

  always_comb begin
    pc_plus4   = pc + 32'd4;
    // jump dominates a simultaneous branch.
    taken      = jump | (br_en & (alu_zero ^ br_inv));
    nxt        = taken ? clear_lsb(target) : pc_plus4;
    // Only a taken target can be misaligned; pc_plus4 keeps pc's alignment.
    bad_target = taken & nxt[1];
  end

endmodule

// File: rtl/rv_fetch_pc.sv
// Program-counter and instruction-fetch stage of the single-cycle RV32I core.
// Fetches one instruction over a req/ack handshake, holds it while the
// datapath executes, then advances the PC (sequential, branch or jump).
//  clk          in   1   core clock, rising edge
//  rst          in   1   asynchronous active-high reset
//  imem_req     out  1   fetch request, held until imem_ack
//  imem_addr    out  32  fetch address (== pc)
//  imem_ack     in   1   imem_rdata is valid this cycle
//  imem_rdata   in   32  fetched instruction word
//  instr        out  32  latched instruction for decode/ALU
//  instr_valid  out  1   instr is valid and executing
//  pc           out  32  address of the current instruction
//  pc_plus4     out  32  pc + 4 (link value)
//  ex_done      in   1   datapath finished instr
//  br_en        in   1   conditional branch
//  br_inv       in   1   invert branch condition
//  alu_zero     in   1   ALU zero flag
//  jump         in   1   unconditional jump
//  target       in   32  branch/jump target
//  misalign     out  1   sticky misaligned-target flag (core halts)
//  retired      out  32  completed instruction count (wraps)
module rv_fetch_pc
  import rv_fetch_pc_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT,
  parameter int unsigned XLEN      = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        ex_done,
  input  logic        br_en,
  input  logic        br_inv,
  input  logic        alu_zero,
  input  logic        jump,
  input  logic [31:0] target,
  output logic        misalign,
  output logic [31:0] retired
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] retired_q, retired_d;
  logic            valid_q, valid_d;
  logic            misalign_q, misalign_d;
  // Low during reset and for the first cycle after, so imem_req only rises
  // on the first clock edge after rst falls.
  logic            started_q;

  logic [31:0] nxt;
  logic        taken;
  logic        bad_target;

  rv_fetch_pc_next_pc u_next_pc (
    .pc         (pc_q),
    .br_en      (br_en),
    .br_inv     (br_inv),
    .alu_zero   (alu_zero),
    .jump       (jump),
    .target     (target),
    .pc_plus4   (pc_plus4),
    .taken      (taken),
    .nxt        (nxt),
    .bad_target (bad_target)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started_q <= 1'b0;
    end else begin
      started_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;
    retired_d  = retired_q;
    unique case (state_q)
      S_FETCH: begin
        if (started_q && imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ex_done) begin
          valid_d = 1'b0;
          if (bad_target) begin
            // pc stays on the offending instruction for debug.
            misalign_d = 1'b1;
            state_d    = S_HALT;
          end else begin
            pc_d      = nxt;
            retired_d = retired_q + 32'd1;
            state_d   = S_FETCH;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_VEC;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      retired_q  <= retired_d;
    end
  end

  assign imem_req    = started_q && (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign misalign    = misalign_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_rv_fetch_pc.sv
// Randomized self-checking bench for rv_fetch_pc against an
// instruction-level reference model (pc, retired count, halt flag).
module tb_rv_fetch_pc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        ex_done = 1'b0;
  logic        br_en = 1'b0;
  logic        br_inv = 1'b0;
  logic        alu_zero = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] target = '0;
  logic        misalign;
  logic [31:0] retired;

  rv_fetch_pc dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .ex_done     (ex_done),
    .br_en       (br_en),
    .br_inv      (br_inv),
    .alu_zero    (alu_zero),
    .jump        (jump),
    .target      (target),
    .misalign    (misalign),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural view only.
  logic [31:0] m_pc;
  logic [31:0] m_retired;
  logic        m_halted;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_arch(input string tag);
    check_eq({tag, "_pc"}, pc, m_pc);
    check_eq({tag, "_pc4"}, pc_plus4, m_pc + 32'd4);
    check_eq({tag, "_ret"}, retired, m_retired);
    check_eq({tag, "_mis"}, {31'd0, misalign}, {31'd0, m_halted});
  endtask

  // Asserts reset at a negedge with an ack pending; the ack is held across
  // release and must be discarded. Leaves the bench at a negedge with req=1.
  task automatic apply_reset();
    @(negedge clk);
    rst      = 1'b1;
    imem_ack = 1'b1;
    ex_done  = 1'b0;
    #1;
    m_pc = 32'h0; m_retired = 32'h0; m_halted = 1'b0;
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_instr", instr, 32'h0);
    check_arch("rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rel_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    check_eq("rel_req1", {31'd0, imem_req}, 32'd1);
    check_eq("rel_ackdisc", {31'd0, instr_valid}, 32'd0);
    imem_ack = 1'b0;
  endtask

  // One instruction from a negedge in fetch: flat wait cycles before ack,
  // elat busy cycles before ex_done. Leaves the bench at a negedge.
  task automatic do_instr(input int flat, input int elat, input logic [31:0] word,
                          input logic j, input logic be, input logic bi,
                          input logic az, input logic [31:0] tgt);
    logic        tk;
    logic [31:0] dest;
    check_eq("f_req", {31'd0, imem_req}, 32'd1);
    check_eq("f_addr", imem_addr, m_pc);
    for (int i = 0; i < flat; i++) begin
      imem_ack = 1'b0;
      ex_done  = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      check_eq("fw_req", {31'd0, imem_req}, 32'd1);
      check_eq("fw_addr", imem_addr, m_pc);
      check_eq("fw_valid", {31'd0, instr_valid}, 32'd0);
    end
    ex_done    = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check_eq("x_instr", instr, word);
    check_eq("x_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("x_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < elat; i++) begin
      imem_ack = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      check_eq("xw_instr", instr, word);
      check_eq("xw_valid", {31'd0, instr_valid}, 32'd1);
      check_arch("xw");
    end
    imem_ack = 1'b0;
    ex_done  = 1'b1;
    jump = j; br_en = be; br_inv = bi; alu_zero = az; target = tgt;
    @(negedge clk);
    ex_done = 1'b0;
    jump = 1'b0; br_en = 1'b0;
    tk   = j || (be && (az != bi));
    dest = tgt & 32'hFFFF_FFFE;
    if (tk && (dest % 4 != 0)) begin
      m_halted = 1'b1;
    end else begin
      m_pc      = tk ? dest : m_pc + 32'd4;
      m_retired = m_retired + 32'd1;
    end
    check_eq("d_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("d_req", {31'd0, imem_req}, {31'd0, !m_halted});
    check_arch("d");
  endtask

  task automatic check_halted_frozen();
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1;
      ex_done  = 1'b1;
      jump     = 1'b1;
      target   = $urandom & 32'hFFFF_FFFC;
      @(negedge clk);
      check_eq("h_req", {31'd0, imem_req}, 32'd0);
      check_eq("h_valid", {31'd0, instr_valid}, 32'd0);
      check_arch("h");
    end
    imem_ack = 1'b0; ex_done = 1'b0; jump = 1'b0;
  endtask

  initial begin
    logic [31:0] t;
    logic        j, be, bi, az;
    // Directed scenarios.
    apply_reset();
    do_instr(0, 0, 32'h0050_0093, 0, 0, 0, 0, 32'h0);
    do_instr(3, 1, 32'h0000_0013, 0, 0, 0, 0, 32'h0);
    do_instr(1, 0, 32'h0000_0063, 0, 1, 0, 1, 32'h40);  // beq taken
    check_eq("beq_pc", pc, 32'h40);
    do_instr(0, 2, 32'h0000_0063, 0, 1, 0, 0, 32'h80);  // beq not taken
    check_eq("beq_nt", pc, 32'h44);
    do_instr(0, 0, 32'h0000_1063, 0, 1, 1, 1, 32'h80);  // bne not taken
    check_eq("bne_nt", pc, 32'h48);
    do_instr(0, 0, 32'h0000_006F, 1, 1, 0, 0, 32'h48);  // 1-instr loop
    check_eq("loop_pc", pc, 32'h48);
    do_instr(0, 0, 32'h0000_006F, 1, 0, 0, 0, 32'h103); // -> 0x102 misaligned
    check_eq("mis_pc", pc, 32'h48);
    check_halted_frozen();

    // Reset mid-exec: asynchronous clear, not retired.
    apply_reset();
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("rx_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rx_ret", retired, 32'd0);
    check_eq("rx_instr", instr, 32'd0);
    rst = 1'b0;
    apply_reset();
    // Reset mid-fetch after one retirement.
    do_instr(0, 0, 32'h0000_0013, 0, 0, 0, 0, 32'h0);
    #2 rst = 1'b1;
    #1;
    check_eq("rf_pc", pc, 32'h0);
    check_eq("rf_ret", retired, 32'd0);
    check_eq("rf_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b0;
    apply_reset();

    // PC and retired counter wrap.
    do_instr(0, 0, 32'h0000_006F, 1, 0, 0, 0, 32'hFFFF_FFFD);
    check_eq("top_pc", pc, 32'hFFFF_FFFC);
    dut.retired_q = 32'hFFFF_FFFF;
    m_retired     = 32'hFFFF_FFFF;
    #1;
    do_instr(0, 0, 32'h0000_0013, 0, 1, 0, 0, 32'h10);
    check_eq("wrap_pc", pc, 32'h0);
    check_eq("wrap_ret", retired, 32'h0);

    // Randomized program walk.
    apply_reset();
    for (int n = 0; n < 300; n++) begin
      j  = ($urandom_range(0, 5) == 0);
      be = ($urandom_range(0, 2) == 0);
      bi = $urandom_range(0, 1) == 1;
      az = $urandom_range(0, 1) == 1;
      t  = {22'd0, $urandom_range(0, 255), 2'b00};
      if ($urandom_range(0, 3) == 0) t = t | 32'h1;
      if ($urandom_range(0, 24) == 0) t = t | 32'h2;
      do_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom, j, be, bi, az, t);
      if (m_halted) begin
        check_halted_frozen();
        apply_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
